// File: rtl/mmio_console_ctrl.sv
// MMIO console/cycle/halt unit: 16-byte register window, console byte FIFO with
// valid/ready drain, free-running cycle counter, drained halt. Option: MMIO_EXIT_CODE_EN.
module mmio_console_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_FFF0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_do_read,
  input  logic [3:0]            req_do_write,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  halt,
  output logic [7:0]            exit_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [3:0]            offset;
  logic                  hit, is_write, is_read, console_wr, accept, halt_wr;
  logic                  push, pop, full, empty;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [7:0]            mem [FIFO_DEPTH];
  logic [31:0]           cycle_cnt;
  logic [31:0]           status;
  logic [DATA_WIDTH-1:0] rd_val;

  // Only the low byte of write data is ever consumed.
  logic unused_data_bits;
  assign unused_data_bits = ^req_data[DATA_WIDTH-1:8];

  assign offset     = req_addr[3:0];
  assign hit        = req_valid && (req_addr[ADDR_WIDTH-1:4] == BASE[ADDR_WIDTH-1:4]);
  assign is_write   = |req_do_write;
  assign is_read    = (|req_do_read) && !is_write;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign console_wr = hit && (offset == 4'h8) && req_do_write[0];

  // Backpressure uses the registered full flag, so a same-cycle pop cannot lift it.
  assign req_ready  = reset && !(console_wr && full);
  assign accept     = hit && req_ready;
  assign halt_wr    = accept && (offset == 4'hC) && is_write;
  assign push       = accept && console_wr && (state == ST_RUN);
  assign pop        = !empty && tx_ready;

  assign tx_valid   = !empty;
  assign tx_data    = empty ? 8'h00 : mem[rd_ptr];
  assign halt       = (state == ST_HALTED);

`ifdef MMIO_EXIT_CODE_EN
  logic [7:0] exit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           exit_q <= 8'h00;
    else if (halt_wr && state == ST_RUN)  exit_q <= req_data[7:0];
  end

  assign exit_code = exit_q;
`else
  assign exit_code = 8'h00;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    status            = '0;
    status[CNT_W-1:0] = count;
    status[16]        = full;
    status[17]        = empty;
    status[18]        = (state == ST_DRAIN);
    status[31:24]     = exit_code;
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      4'h0:    rd_val = cycle_cnt;
      4'h4:    rd_val = status;
      default: rd_val = '0;
    endcase
  end

  // Emptiness is checked on the registered count, so a HALT accepted on an
  // empty FIFO still spends one cycle in DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (halt_wr) state_nxt = ST_DRAIN;
      ST_DRAIN: if (empty)   state_nxt = ST_HALTED;
      default:  state_nxt = ST_HALTED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      cycle_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= accept;
      if (state != ST_HALTED) cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) begin
        rsp_tag  <= req_tag;
        rsp_data <= is_read ? rd_val : '0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the count/pointers define validity and tx_data is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_data[7:0];
  end

endmodule

// File: tb/tb_mmio_console_ctrl.sv
// Randomized scoreboard bench for mmio_console_ctrl: a queue-based reference model
// predicts responses, console bytes, halt timing and handshake; a monitor checks them.
module tb_mmio_console_ctrl;

  localparam logic [31:0] BASE  = 32'h0002_FFF0;
  localparam int          DEPTH = 16;
  localparam int PH_RUN = 0, PH_DRAIN = 1, PH_HALTED = 2;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_do_read, req_do_write;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        halt;
  logic [7:0]  exit_code;

  int          total = 0;
  int          bad   = 0;
  int unsigned tb_cyc = 0;
  bit          model_en = 0;
  bit          rand_tx  = 0;
  logic [7:0]  next_tag;

  // Reference model state
  logic [7:0]  bytes_q[$];
  int          phase;
  logic [31:0] cyc_model;
  logic [7:0]  exp_exit;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic [7:0]  tag;
  } rsp_t;
  rsp_t rsp_q[$];

  mmio_console_ctrl #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TAG_WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_do_read (req_do_read),
    .req_do_write(req_do_write),
    .req_data    (req_data),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .halt        (halt),
    .exit_code   (exit_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  function automatic logic [31:0] status_model();
    logic [31:0] s;
    s     = 32'(bytes_q.size());
    s[16] = (bytes_q.size() == DEPTH);
    s[17] = (bytes_q.size() == 0);
    s[18] = (phase == PH_DRAIN);
`ifdef MMIO_EXIT_CODE_EN
    s = s | (32'(exp_exit) << 24);
`endif
    return s;
  endfunction

  // Reference model: evaluated between edges, predicts what the next posedge does.
  always @(negedge clk) begin
    int          n, ph0;
    bit          hit, wr, rd, rdy, acc;
    logic [31:0] rv;
    if (model_en) begin
      n   = bytes_q.size();
      ph0 = phase;
      check("tx_valid", 32'(tx_valid), 32'(n > 0));
      if (n > 0) check("tx_data", 32'(tx_data), 32'(bytes_q[0]));
      check("halt", 32'(halt), 32'(phase == PH_HALTED));
      check("exit_code", 32'(exit_code), 32'(exp_exit));

      hit = req_valid && ((req_addr >> 4) == (BASE >> 4));
      rdy = !(hit && req_addr[3:0] == 4'h8 && req_do_write[0] && n == DEPTH);
      check("req_ready", 32'(req_ready), 32'(rdy));
      acc = hit && rdy;
      wr  = |req_do_write;
      rd  = (|req_do_read) && !wr;

      if (acc) begin
        rv = 32'h0;
        if (rd && req_addr[3:0] == 4'h0) rv = cyc_model;
        if (rd && req_addr[3:0] == 4'h4) rv = status_model();
        rsp_q.push_back('{due: tb_cyc + 1, data: rv, tag: req_tag});
      end

      if (ph0 != PH_HALTED) cyc_model = cyc_model + 32'd1;
      if (ph0 == PH_DRAIN && n == 0) phase = PH_HALTED;
      else if (ph0 == PH_RUN && acc && req_addr[3:0] == 4'hC && wr) begin
        phase = PH_DRAIN;
`ifdef MMIO_EXIT_CODE_EN
        exp_exit = req_data[7:0];
`endif
      end
      if (n > 0 && tx_ready) void'(bytes_q.pop_front());
      if (acc && req_addr[3:0] == 4'h8 && req_do_write[0] && ph0 == PH_RUN)
        bytes_q.push_back(req_data[7:0]);
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (model_en) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0 || rsp_q[0].due != tb_cyc) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          check("rsp_data", rsp_data, rsp_q[0].data);
          check("rsp_tag", 32'(rsp_tag), 32'(rsp_q[0].tag));
          void'(rsp_q.pop_front());
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= tb_cyc) begin
        check("rsp_missing", 32'(rsp_valid), 32'h1);
        void'(rsp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_tx) begin
      #1 tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [3:0] rd,
                        input logic [3:0] wr, input logic [31:0] data);
    int waited = 0;
    bit done   = 0;
    req_valid    = 1'b1;
    req_addr     = addr;
    req_do_read  = rd;
    req_do_write = wr;
    req_data     = data;
    req_tag      = next_tag;
    next_tag     = next_tag + 8'd1;
    while (!done) begin
      @(negedge clk);
      if (req_ready) done = 1;
      else if (++waited > 64) begin
        check("req_accept_timeout", 32'(req_ready), 32'h1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    req_valid    = 1'b0;
    req_do_read  = 4'h0;
    req_do_write = 4'h0;
  endtask

  task automatic assert_reset();
    model_en = 0;
    rsp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_exit_code", 32'(exit_code), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_cycle", dut.cycle_cnt, 32'h0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bytes_q.delete();
    phase     = PH_RUN;
    cyc_model = 32'h0;
    exp_exit  = 8'h00;
    model_en  = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  off;
    clk = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    req_do_read = '0; req_do_write = '0; req_tag = '0; tx_ready = 1'b1;
    next_tag = 8'h10;

    assert_reset();
    release_reset();

    // Cycle counter read ten cycles after reset release.
    idle(10);
    do_req(BASE, 4'hF, 4'h0, 32'h0);

    // "Hi" through the console, then status shows empty.
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h48);
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h69);
    idle(4);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);

    // Fill the FIFO with the sink stalled; the 17th write waits for a pop.
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_req(BASE + 32'h8, 4'h0, 4'h1, $urandom);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);
    fork
      do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h5A);
      begin idle(4); tx_ready = 1'b1; end
    join
    idle(20);

    // Randomized traffic, excluding HALT writes.
    rand_tx = 1;
    repeat (250) begin
      case ($urandom_range(0, 7))
        0, 1: do_req(BASE + 32'h8, 4'h0, 4'($urandom_range(1, 15)), $urandom);
        2:    do_req(BASE, 4'($urandom_range(1, 15)), 4'h0, 32'h0);
        3:    do_req(BASE + 32'h4, 4'($urandom_range(1, 15)), 4'h0, 32'h0);
        4: begin
          off = 4'($urandom_range(0, 15));
          do_req(BASE + 32'(off), 4'($urandom_range(1, 15)), 4'h0, 32'h0);
        end
        5: begin
          off = 4'($urandom_range(0, 15));
          if (off == 4'hC) off = 4'hD;
          do_req(BASE + 32'(off), 4'h0, 4'($urandom_range(1, 15)), $urandom);
        end
        6: begin
          a = $urandom;
          if ((a >> 4) == (BASE >> 4)) a = a ^ 32'h100;
          do_req(a, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
        end
        default: do_req(BASE + 32'h8, 4'hF, 4'h1, $urandom);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_tx = 0;
    idle(1);
    tx_ready = 1'b1;
    idle(24);

    // Halt with three bytes pending; drain, then counter frozen.
    tx_ready = 1'b0;
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h61);
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h62);
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h63);
    do_req(BASE + 32'hC, 4'h0, 4'h1, 32'h2A);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h78);
    do_req(BASE + 32'hC, 4'h0, 4'hF, 32'h55);
    idle(3);
    tx_ready = 1'b1;
    idle(8);
    do_req(BASE, 4'hF, 4'h0, 32'h0);
    do_req(BASE, 4'hF, 4'h0, 32'h0);
    do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h79);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);
`ifdef MMIO_EXIT_CODE_EN
    check("exit_code_latched", 32'(exit_code), 32'h2A);
`else
    check("exit_code_latched", 32'(exit_code), 32'h0);
`endif
    do_req(32'h0003_0000, 4'hF, 4'h0, 32'h0);
    do_req(32'h0003_0000, 4'h0, 4'hF, 32'h1);
    idle(3);

    // Reset in DRAIN with five bytes queued clears everything at once.
    #2;
    assert_reset();
    release_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_req(BASE + 32'h8, 4'h0, 4'h1, 32'h30 + 32'(i));
    do_req(BASE + 32'hC, 4'h0, 4'h1, 32'h07);
    idle(2);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);
    idle(2);
    #2;
    assert_reset();
    release_reset();

    // HALT accepted with an empty FIFO: one DRAIN cycle, then HALTED.
    tx_ready = 1'b1;
    idle(3);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);
    do_req(BASE + 32'hC, 4'h0, 4'h1, 32'h99);
    do_req(BASE + 32'h4, 4'hF, 4'h0, 32'h0);
    idle(4);
    do_req(BASE, 4'hF, 4'h0, 32'h0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
